// File: rtl/uart_fifo_core.sv
// UART core: shared baud generator, RX/TX engines with optional parity, and a FIFO on each side.
// The RX FIFO is first-word-fall-through; its head is held in a register and reads 0 when empty.
module uart_fifo_core #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16,
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [DIV_W-1:0] i_div,
   input  logic [1:0]       i_parity_mode,
   input  logic             i_rx,
   output logic             o_tx,
   input  logic             i_tx_wr,
   input  logic [DBIT-1:0]  i_tx_data,
   output logic             o_tx_full,
   input  logic             i_rx_rd,
   output logic [DBIT-1:0]  o_rx_data,
   output logic             o_rx_empty,
   output logic             o_parity_err,
   output logic             o_frame_err,
   output logic             o_rx_overrun,
   input  logic             i_err_clr,
   output logic             o_tx_busy
);

   localparam int unsigned DEPTH    = 2 ** FIFO_AW;
   localparam int unsigned CNT_W    = FIFO_AW + 1;
   localparam int unsigned TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
   localparam int unsigned TICK_W   = $clog2(TICK_MAX);
   localparam int unsigned BIT_W    = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(15);
   localparam logic [TICK_W-1:0] START_MID = TICK_W'(7);
   localparam logic [TICK_W-1:0] SB_LAST   = TICK_W'(SB_TICK - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DBIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } uart_state_t;

   // ---------------- baud generator ----------------
   logic [DIV_W-1:0] baud_cnt;
   logic [DIV_W-1:0] baud_last_c;
   logic             baud_tick;
   logic             tx_restart_c;

   assign baud_last_c = (i_div > DIV_W'(1)) ? i_div - DIV_W'(1) : '0;
   assign baud_tick   = (baud_cnt >= baud_last_c);

   // Restart the count when TX leaves idle so its start bit is a full bit time
   always_ff @(posedge i_clock) begin
      if (!i_reset)                       baud_cnt <= '0;
      else if (baud_tick || tx_restart_c) baud_cnt <= '0;
      else                                baud_cnt <= baud_cnt + DIV_W'(1);
   end

   // ---------------- RX synchroniser ----------------
   logic rx_meta;
   logic rx_sync;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
      end
   end

   // ---------------- RX engine ----------------
   uart_state_t       rx_state, rx_state_n;
   logic [TICK_W-1:0] rx_s, rx_s_n;
   logic [BIT_W-1:0]  rx_n, rx_n_n;
   logic [DBIT-1:0]   rx_b, rx_b_n;
   logic [1:0]        rx_mode, rx_mode_n;
   logic              rx_par_en_c;
   logic              rx_exp_par_c;
   logic              rx_push_c;
   logic              perr_set_c;
   logic              ferr_set_c;

   assign rx_par_en_c  = (rx_mode == 2'b01) || (rx_mode == 2'b10);
   assign rx_exp_par_c = (^rx_b) ^ (rx_mode == 2'b10);

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         rx_state <= S_IDLE;
         rx_s     <= '0;
         rx_n     <= '0;
         rx_b     <= '0;
         rx_mode  <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_s     <= rx_s_n;
         rx_n     <= rx_n_n;
         rx_b     <= rx_b_n;
         rx_mode  <= rx_mode_n;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_s_n     = rx_s;
      rx_n_n     = rx_n;
      rx_b_n     = rx_b;
      rx_mode_n  = rx_mode;
      rx_push_c  = 1'b0;
      perr_set_c = 1'b0;
      ferr_set_c = 1'b0;
      case (rx_state)
         S_IDLE: begin
            if (!rx_sync) begin
               rx_state_n = S_START;
               rx_s_n     = '0;
               rx_mode_n  = i_parity_mode;
            end
         end
         S_START: begin
            if (baud_tick) begin
               if (rx_s == START_MID) begin
                  rx_s_n     = '0;
                  rx_n_n     = '0;
                  rx_state_n = rx_sync ? S_IDLE : S_DATA;
               end else begin
                  rx_s_n = rx_s + TICK_W'(1);
               end
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (rx_s == OS_LAST) begin
                  rx_s_n = '0;
                  rx_b_n = (rx_b >> 1) | (DBIT'(rx_sync) << (DBIT - 1));
                  if (rx_n == DATA_LAST) rx_state_n = rx_par_en_c ? S_PARITY : S_STOP;
                  else                   rx_n_n     = rx_n + BIT_W'(1);
               end else begin
                  rx_s_n = rx_s + TICK_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (baud_tick) begin
               if (rx_s == OS_LAST) begin
                  rx_s_n     = '0;
                  rx_state_n = S_STOP;
                  perr_set_c = (rx_sync != rx_exp_par_c);
               end else begin
                  rx_s_n = rx_s + TICK_W'(1);
               end
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               if (rx_s == SB_LAST) begin
                  rx_state_n = S_IDLE;
                  ferr_set_c = !rx_sync;
                  rx_push_c  = rx_sync;
               end else begin
                  rx_s_n = rx_s + TICK_W'(1);
               end
            end
         end
         default: rx_state_n = S_IDLE;
      endcase
   end

   // ---------------- RX FIFO ----------------
   logic [DBIT-1:0]    rx_mem [DEPTH];
   logic [FIFO_AW-1:0] rx_wp, rx_wp_n, rx_rp, rx_rp_n;
   logic [CNT_W-1:0]   rx_cnt, rx_cnt_n;
   logic [DBIT-1:0]    rx_head_n;
   logic               rx_pop_c, rx_full_c, rx_wr_ok_c, ovr_set_c;

   always_comb begin
      rx_pop_c   = i_rx_rd && (rx_cnt != '0);
      rx_full_c  = (rx_cnt == CNT_FULL);
      rx_wr_ok_c = rx_push_c && (!rx_full_c || rx_pop_c);
      ovr_set_c  = rx_push_c && rx_full_c && !rx_pop_c;
      rx_rp_n    = rx_pop_c ? rx_rp + FIFO_AW'(1) : rx_rp;
      rx_wp_n    = rx_wr_ok_c ? rx_wp + FIFO_AW'(1) : rx_wp;
      rx_cnt_n   = rx_cnt;
      if (rx_wr_ok_c && !rx_pop_c)      rx_cnt_n = rx_cnt + CNT_W'(1);
      else if (!rx_wr_ok_c && rx_pop_c) rx_cnt_n = rx_cnt - CNT_W'(1);
      // Next head bypasses the array when the new word lands at the read slot
      if (rx_cnt_n == '0)                         rx_head_n = '0;
      else if (rx_wr_ok_c && (rx_wp == rx_rp_n))  rx_head_n = rx_b;
      else                                        rx_head_n = rx_mem[rx_rp_n];
   end

   always_ff @(posedge i_clock) begin
      if (i_reset && rx_wr_ok_c) rx_mem[rx_wp] <= rx_b;
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         rx_wp      <= '0;
         rx_rp      <= '0;
         rx_cnt     <= '0;
         o_rx_data  <= '0;
         o_rx_empty <= 1'b1;
      end else begin
         rx_wp      <= rx_wp_n;
         rx_rp      <= rx_rp_n;
         rx_cnt     <= rx_cnt_n;
         o_rx_data  <= rx_head_n;
         o_rx_empty <= (rx_cnt_n == '0);
      end
   end

   // Sticky error flags; a same-cycle set beats the clear
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_rx_overrun <= 1'b0;
      end else begin
         o_parity_err <= perr_set_c || (o_parity_err && !i_err_clr);
         o_frame_err  <= ferr_set_c || (o_frame_err && !i_err_clr);
         o_rx_overrun <= ovr_set_c  || (o_rx_overrun && !i_err_clr);
      end
   end

   // ---------------- TX FIFO ----------------
   logic [DBIT-1:0]    tx_mem [DEPTH];
   logic [FIFO_AW-1:0] tx_wp, tx_rp;
   logic [CNT_W-1:0]   tx_cnt, tx_cnt_n;
   logic [DBIT-1:0]    tx_head_c;
   logic               tx_empty_c, tx_wr_ok_c, tx_pop_c;

   assign tx_empty_c = (tx_cnt == '0);
   assign tx_head_c  = tx_mem[tx_rp];
   assign tx_wr_ok_c = i_tx_wr && ((tx_cnt != CNT_FULL) || tx_pop_c);

   always_comb begin
      tx_cnt_n = tx_cnt;
      if (tx_wr_ok_c && !tx_pop_c)      tx_cnt_n = tx_cnt + CNT_W'(1);
      else if (!tx_wr_ok_c && tx_pop_c) tx_cnt_n = tx_cnt - CNT_W'(1);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset && tx_wr_ok_c) tx_mem[tx_wp] <= i_tx_data;
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         tx_wp     <= '0;
         tx_rp     <= '0;
         tx_cnt    <= '0;
         o_tx_full <= 1'b0;
      end else begin
         if (tx_wr_ok_c) tx_wp <= tx_wp + FIFO_AW'(1);
         if (tx_pop_c)   tx_rp <= tx_rp + FIFO_AW'(1);
         tx_cnt    <= tx_cnt_n;
         o_tx_full <= (tx_cnt_n == CNT_FULL);
      end
   end

   // ---------------- TX engine ----------------
   uart_state_t       tx_state, tx_state_n;
   logic [TICK_W-1:0] tx_s, tx_s_n;
   logic [BIT_W-1:0]  tx_n, tx_n_n;
   logic [DBIT-1:0]   tx_sh, tx_sh_n;
   logic [1:0]        tx_mode, tx_mode_n;
   logic              tx_par, tx_par_n;
   logic              tx_par_en_c;
   logic              tx_bit_c;

   assign tx_par_en_c = (tx_mode == 2'b01) || (tx_mode == 2'b10);

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         tx_state  <= S_IDLE;
         tx_s      <= '0;
         tx_n      <= '0;
         tx_sh     <= '0;
         tx_mode   <= '0;
         tx_par    <= 1'b0;
         o_tx      <= 1'b1;
         o_tx_busy <= 1'b0;
      end else begin
         tx_state  <= tx_state_n;
         tx_s      <= tx_s_n;
         tx_n      <= tx_n_n;
         tx_sh     <= tx_sh_n;
         tx_mode   <= tx_mode_n;
         tx_par    <= tx_par_n;
         o_tx      <= tx_bit_c;
         o_tx_busy <= (tx_state_n != S_IDLE);
      end
   end

   always_comb begin
      tx_state_n   = tx_state;
      tx_s_n       = tx_s;
      tx_n_n       = tx_n;
      tx_sh_n      = tx_sh;
      tx_mode_n    = tx_mode;
      tx_par_n     = tx_par;
      tx_pop_c     = 1'b0;
      tx_restart_c = 1'b0;
      tx_bit_c     = 1'b1;
      case (tx_state)
         S_IDLE: begin
            if (!tx_empty_c) begin
               tx_pop_c     = 1'b1;
               tx_restart_c = 1'b1;
            end
         end
         S_START: begin
            if (baud_tick) begin
               if (tx_s == OS_LAST) begin
                  tx_state_n = S_DATA;
                  tx_s_n     = '0;
                  tx_n_n     = '0;
               end else begin
                  tx_s_n = tx_s + TICK_W'(1);
               end
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (tx_s == OS_LAST) begin
                  tx_s_n  = '0;
                  tx_sh_n = tx_sh >> 1;
                  if (tx_n == DATA_LAST) tx_state_n = tx_par_en_c ? S_PARITY : S_STOP;
                  else                   tx_n_n     = tx_n + BIT_W'(1);
               end else begin
                  tx_s_n = tx_s + TICK_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (baud_tick) begin
               if (tx_s == OS_LAST) begin
                  tx_s_n     = '0;
                  tx_state_n = S_STOP;
               end else begin
                  tx_s_n = tx_s + TICK_W'(1);
               end
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               if (tx_s == SB_LAST) begin
                  if (!tx_empty_c) tx_pop_c   = 1'b1;
                  else             tx_state_n = S_IDLE;
               end else begin
                  tx_s_n = tx_s + TICK_W'(1);
               end
            end
         end
         default: tx_state_n = S_IDLE;
      endcase
      // Popping loads the next frame; from STOP this chains with no idle gap
      if (tx_pop_c) begin
         tx_state_n = S_START;
         tx_s_n     = '0;
         tx_sh_n    = tx_head_c;
         tx_mode_n  = i_parity_mode;
         tx_par_n   = (^tx_head_c) ^ (i_parity_mode == 2'b10);
      end
      case (tx_state_n)
         S_START:  tx_bit_c = 1'b0;
         S_DATA:   tx_bit_c = tx_sh_n[0];
         S_PARITY: tx_bit_c = tx_par_n;
         default:  tx_bit_c = 1'b1;
      endcase
   end

endmodule
